// File: rtl/layer_sequencer.sv
// layer_sequencer: streams a stored input vector to a layer of neurons,
// collects each neuron's result (bounded by a timeout), then serializes
// the results over a valid/ready handshake.
module layer_sequencer #(
    parameter int numWeight = 784,
    parameter int numNeuron = 30,
    parameter int dataWidth = 16,
    parameter int waitMax   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_wr_en,
    input  logic [$clog2(numWeight)-1:0]   in_wr_addr,
    input  logic [dataWidth-1:0]           in_wr_data,
    output logic [dataWidth-1:0]           nr_input,
    output logic                           nr_input_valid,
    input  logic [numNeuron*dataWidth-1:0] nr_out,
    input  logic [numNeuron-1:0]           nr_outvalid,
    output logic [dataWidth-1:0]           res_data,
    output logic [$clog2(numNeuron)-1:0]   res_index,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int AW = $clog2(numWeight);
    localparam int IW = $clog2(numNeuron);
    localparam int CW = $clog2(numWeight + 1);
    localparam int WW = $clog2(waitMax + 1);

    localparam logic [CW-1:0] RD_END   = CW'(numWeight);
    localparam logic [IW-1:0] LAST_IDX = IW'(numNeuron - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(waitMax);
    localparam logic [AW:0]   BUF_SIZE = (AW + 1)'(numWeight);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_NR,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        rd_cnt_q;
    logic [WW-1:0]        wait_cnt_q;
    logic [WW-1:0]        wait_cnt_d;
    logic [numNeuron-1:0] mask_q;
    logic [numNeuron-1:0] mask_d;
    logic [dataWidth-1:0] result_q [numNeuron];
    logic [dataWidth-1:0] result_d [numNeuron];
    logic [IW-1:0]        res_index_d;

    logic [dataWidth-1:0] nr_input_q;
    logic                 nr_input_valid_q;
    logic [dataWidth-1:0] res_data_q;
    logic [IW-1:0]        res_index_q;
    logic                 res_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic [dataWidth-1:0] buf_mem [numWeight];

    // Input buffer: host writes land only while the sequencer is idle.
    // NOTE: the buffer is plain storage with no reset; its contents survive a reset and stay usable.
    always_ff @(posedge clk) begin
        if (in_wr_en && state_q == S_IDLE && {1'b0, in_wr_addr} < BUF_SIZE) begin
            buf_mem[in_wr_addr] <= in_wr_data;
        end
    end

    // Collection view: result/mask as they stand after this cycle's neuron pulses.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        result_d    = result_q;
        mask_d      = mask_q;
        wait_cnt_d  = wait_cnt_q + 1'b1;
        res_index_d = res_index_q + 1'b1;
        if (state_q == S_WAIT_NR) begin
            for (int k = 0; k < numNeuron; k++) begin
                if (nr_outvalid[k]) begin
                    result_d[k] = nr_out[k*dataWidth +: dataWidth];
                    mask_d[k]   = 1'b1;
                end
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            rd_cnt_q         <= '0;
            wait_cnt_q       <= '0;
            mask_q           <= '0;
            for (int k = 0; k < numNeuron; k++) result_q[k] <= '0;
            nr_input_q       <= '0;
            nr_input_valid_q <= 1'b0;
            res_data_q       <= '0;
            res_index_q      <= '0;
            res_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_STREAM;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        rd_cnt_q <= '0;
                    end
                end
                S_STREAM: begin
                    if (rd_cnt_q == RD_END) begin
                        nr_input_valid_q <= 1'b0;
                        state_q          <= S_WAIT_NR;
                        mask_q           <= '0;
                        wait_cnt_q       <= '0;
                        for (int k = 0; k < numNeuron; k++) result_q[k] <= '0;
                    end else begin
                        nr_input_q       <= buf_mem[rd_cnt_q[AW-1:0]];
                        nr_input_valid_q <= 1'b1;
                        rd_cnt_q         <= rd_cnt_q + 1'b1;
                    end
                end
                S_WAIT_NR: begin
                    result_q   <= result_d;
                    mask_q     <= mask_d;
                    wait_cnt_q <= wait_cnt_d;
                    if (&mask_d || wait_cnt_d == WAIT_END) begin
                        // A complete mask wins over a coincident timeout.
                        err_q       <= ~(&mask_d);
                        state_q     <= S_DRAIN;
                        res_valid_q <= 1'b1;
                        res_index_q <= '0;
                        res_data_q  <= result_d[0];
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        if (res_index_q == LAST_IDX) begin
                            res_valid_q <= 1'b0;
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                        end else begin
                            res_index_q <= res_index_d;
                            res_data_q  <= result_q[res_index_d];
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign nr_input       = nr_input_q;
    assign nr_input_valid = nr_input_valid_q;
    assign res_data       = res_data_q;
    assign res_index      = res_index_q;
    assign res_valid      = res_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized scoreboard bench for layer_sequencer.
module tb_layer_sequencer;

    localparam int NW = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int WM = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic               in_wr_en;
    logic [1:0]         in_wr_addr;
    logic [DW-1:0]      in_wr_data;
    logic [DW-1:0]      nr_input;
    logic               nr_input_valid;
    logic [NN*DW-1:0]   nr_out;
    logic [NN-1:0]      nr_outvalid;
    logic [DW-1:0]      res_data;
    logic [1:0]         res_index;
    logic               res_valid;
    logic               res_ready;
    logic               busy;
    logic               done;
    logic               err;

    layer_sequencer #(
        .numWeight(NW),
        .numNeuron(NN),
        .dataWidth(DW),
        .waitMax  (WM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_wr_en      (in_wr_en),
        .in_wr_addr    (in_wr_addr),
        .in_wr_data    (in_wr_data),
        .nr_input      (nr_input),
        .nr_input_valid(nr_input_valid),
        .nr_out        (nr_out),
        .nr_outvalid   (nr_outvalid),
        .res_data      (res_data),
        .res_index     (res_index),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } res_t;

    logic [DW-1:0] model_buf [NW];
    logic [DW-1:0] exp_in_q [$];
    res_t          exp_res_q [$];

    // Input-stream monitor: every valid sample must be the next expected buffer word.
    always @(negedge clk) begin
        if (rst && nr_input_valid) begin
            if (exp_in_q.size() == 0) check("nr_input_unexpected", {31'd0, nr_input_valid}, 32'd0);
            else check("nr_input", {16'd0, nr_input}, {16'd0, exp_in_q.pop_front()});
        end
    end

    // Result monitor: checks accepted beats against the scoreboard and stall stability.
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data;
    logic [1:0]    hold_idx;
    res_t          mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            hold_pend = 1'b0;
        end else begin
            if (res_valid && hold_pend) begin
                check("res_data_stable", {16'd0, res_data}, {16'd0, hold_data});
                check("res_index_stable", {30'd0, res_index}, {30'd0, hold_idx});
            end
            hold_pend = res_valid && !res_ready;
            hold_data = res_data;
            hold_idx  = res_index;
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("res_unexpected", {31'd0, res_valid}, 32'd0);
                end else begin
                    mon_e = exp_res_q.pop_front();
                    check("res_index", {30'd0, res_index}, mon_e.idx);
                    check("res_data", {16'd0, res_data}, {16'd0, mon_e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_flags"}, {27'd0, nr_input_valid, res_valid, busy, done, err}, 32'd0);
        check({tag, "_data"}, {nr_input, res_data}, 32'd0);
        check({tag, "_index"}, {30'd0, res_index}, 32'd0);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        start       = 1'b0;
        in_wr_en    = 1'b0;
        in_wr_addr  = '0;
        in_wr_data  = '0;
        nr_out      = '0;
        nr_outvalid = '0;
        res_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        tick();
        rst = 1'b1;
    endtask

    task automatic load_buf(input bit rnd);
        for (int i = 0; i < NW; i++) begin
            model_buf[i] = rnd ? DW'($urandom) : DW'(i + 1);
            in_wr_en     = 1'b1;
            in_wr_addr   = 2'(i);
            in_wr_data   = model_buf[i];
            tick();
        end
        in_wr_en = 1'b0;
    endtask

    // scen: 0 one-hot random order, 1 random overlapping pulses, 2 one neuron silent,
    //       3 fixed 0x10/0x20/0x30 one-hot in order.
    // rmode: 0 ready high, 1 random ready, 2 stall 5 cycles at index 1, 3 reset at index 1.
    task automatic run_pass(input int scen, input int rmode, input bit abuse);
        logic [NN-1:0] sv [WM];
        logic [DW-1:0] sd [WM][NN];
        logic [DW-1:0] mres [NN];
        logic [NN-1:0] got;
        int            perm [NN];
        int            ncyc, c, cnt, budget, held, missing, tmp, j;
        bit            exp_err, saw_done;
        res_t          e;

        for (int i = 0; i < WM; i++) begin
            sv[i] = '0;
            for (int k = 0; k < NN; k++) sd[i][k] = DW'($urandom);
        end
        case (scen)
            0: begin
                for (int k = 0; k < NN; k++) perm[k] = k;
                for (int k = NN - 1; k > 0; k--) begin
                    j = $urandom_range(0, k);
                    tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
                end
                c = 0;
                for (int k = 0; k < NN; k++) begin
                    c += $urandom_range(0, 2);
                    sv[c][perm[k]] = 1'b1;
                    c++;
                end
            end
            1: begin
                for (int i = 0; i < 7; i++) sv[i] = NN'($urandom);
                sv[7] = '1;
            end
            2: begin
                missing = $urandom_range(0, NN - 1);
                for (int i = 0; i < WM; i++) sv[i] = NN'($urandom) & ~(NN'(1) << missing);
            end
            default: begin
                for (int k = 0; k < NN; k++) begin
                    sv[k][k] = 1'b1;
                    sd[k][k] = DW'(16 * (k + 1));
                end
            end
        endcase

        // Reference: last pulse per neuron wins; stop once all seen or after WM cycles.
        for (int k = 0; k < NN; k++) mres[k] = '0;
        got  = '0;
        ncyc = WM;
        for (int i = 0; i < WM; i++) begin
            for (int k = 0; k < NN; k++) begin
                if (sv[i][k]) begin
                    mres[k] = sd[i][k];
                    got[k]  = 1'b1;
                end
            end
            if (&got) begin
                ncyc = i + 1;
                break;
            end
        end
        exp_err = !(&got);

        for (int i = 0; i < NW; i++) exp_in_q.push_back(model_buf[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("busy_at_T1", {31'd0, busy}, 32'd1);
        check("valid_at_T1", {31'd0, nr_input_valid}, 32'd0);
        check("err_cleared_on_start", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("valid_at_T2", {31'd0, nr_input_valid}, 32'd1);

        cnt = 0;
        while (nr_input_valid && cnt < NW + 4) begin
            nr_outvalid = NN'($urandom);
            nr_out      = {$urandom, $urandom};
            if (abuse) begin
                start      = 1'b1;
                in_wr_en   = 1'b1;
                in_wr_addr = 2'($urandom);
                in_wr_data = DW'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        start       = 1'b0;
        in_wr_en    = 1'b0;
        nr_outvalid = '0;
        check("stream_length", cnt, NW);
        check("stream_all_consumed", exp_in_q.size(), 0);

        for (int k = 0; k < NN; k++) begin
            e.idx  = k;
            e.data = mres[k];
            exp_res_q.push_back(e);
        end

        for (int i = 0; i < ncyc; i++) begin
            check("no_res_valid_while_waiting", {31'd0, res_valid}, 32'd0);
            nr_outvalid = sv[i];
            for (int k = 0; k < NN; k++) nr_out[k*DW +: DW] = sd[i][k];
            @(negedge clk);
        end
        nr_outvalid = '0;
        check("drain_entry_valid", {31'd0, res_valid}, 32'd1);
        check("drain_entry_err", {31'd0, err}, {31'd0, exp_err});

        tick();
        budget   = 0;
        held     = 0;
        saw_done = 1'b0;
        while (budget < 60) begin
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            case (rmode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (res_index == 2'd1 && held < 5) begin
                        res_ready = 1'b0;
                        held++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: begin
                    if (res_index == 2'd1) begin
                        rst       = 1'b0;
                        res_ready = 1'b0;
                        break;
                    end
                    res_ready = 1'b1;
                end
            endcase
            tick();
            budget++;
        end

        if (rmode == 3) begin
            @(posedge clk);
            @(negedge clk);
            check_idle_zero("mid_drain_reset");
            exp_res_q.delete();
            exp_in_q.delete();
            tick();
            rst = 1'b1;
        end else begin
            check("drain_completed", {31'd0, saw_done}, 32'd1);
            @(negedge clk);
            check("done_pulse_busy", {30'd0, done, busy}, 32'd3);
            check("results_all_drained", exp_res_q.size(), 0);
            @(negedge clk);
            check("after_done_idle", {30'd0, done, busy}, 32'd0);
            check("err_sticky", {31'd0, err}, {31'd0, exp_err});
            res_ready = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        load_buf(1'b0);
        run_pass(3, 0, 1'b0);
        run_pass(3, 2, 1'b0);
        run_pass(2, 0, 1'b0);
        run_pass(0, 1, 1'b1);
        run_pass(3, 3, 1'b0);
        run_pass(3, 0, 1'b0);
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1) load_buf(1'b1);
            run_pass($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        run_pass(1, 3, 1'b1);
        run_pass(2, 1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter numWeight, default 784, inputs per neuron (= input vector length).
REQ-002 SHALL have parameter numNeuron, default 30, neurons in the driven layer.
REQ-003 SHALL have parameter dataWidth, default 16, input/output sample width.
REQ-004 SHALL have parameter waitMax, default 16, cycle limit for collecting neuron results.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin one layer pass; sampled only in IDLE.
REQ-008 SHALL have port in_wr_en  input  1  input-buffer write strobe.
REQ-009 SHALL have port in_wr_addr  input  $clog2(numWeight)  input-buffer write address.
REQ-010 SHALL have port in_wr_data  input  dataWidth  input-buffer write data.
REQ-011 SHALL have port nr_input  output  dataWidth  sample broadcast to all neurons.
REQ-012 SHALL have port nr_input_valid  output  1  qualifies nr_input.
REQ-013 SHALL have port nr_out  input  numNeuron*dataWidth  neuron outputs; neuron k at bits [k*dataWidth +: dataWidth].
REQ-014 SHALL have port nr_outvalid  input  numNeuron  per-neuron result-valid pulses.
REQ-015 SHALL have port res_data  output  dataWidth  serialized result.
REQ-016 SHALL have port res_index  output  $clog2(numNeuron)  neuron number of res_data.
REQ-017 SHALL have port res_valid  output  1  result handshake valid.
REQ-018 SHALL have port res_ready  input  1  result handshake ready.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-021 SHALL have port err  output  1  sticky collection-timeout flag.

Function
REQ-022 SHALL implement states IDLE, STREAM, WAIT_NR, DRAIN, DONE.
REQ-023 SHALL hold numWeight x dataWidth input buffer; write takes effect when in_wr_en high in IDLE only; writes outside IDLE ignored.
REQ-024 IDLE: start high at edge T -> STREAM at T+1; err cleared at same edge; start outside IDLE ignored.
REQ-025 STREAM: synchronous buffer read; nr_input_valid high for exactly numWeight consecutive cycles starting cycle T+2, nr_input = buffer[0..numWeight-1] in order, no gaps.
REQ-026 After last sample: nr_input_valid low, enter WAIT_NR; collection mask and wait counter cleared on entry.
REQ-027 WAIT_NR: each cycle, for every k with nr_outvalid[k] high, capture nr_out slice k into result register k and set mask bit k; later pulses for k overwrite capture.
REQ-028 nr_outvalid pulses arriving in STREAM cycles SHALL be ignored.
REQ-029 Mask all ones (including bits set same cycle) -> DRAIN next cycle.
REQ-030 Wait counter increments each WAIT_NR cycle; reaching waitMax with mask incomplete -> set err, enter DRAIN; uncaptured results output as zero.
REQ-031 DRAIN: res_valid high, res_index starts 0; on res_valid & res_ready, index increments; res_data = result register[res_index].
REQ-032 res_data/res_index SHALL stay stable while res_valid & !res_ready.
REQ-033 Acceptance of index numNeuron-1 -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-034 No arithmetic on data; all sample paths pass dataWidth bits unmodified.
REQ-035 Output registers only: nr_input, nr_input_valid, res_* , busy, done, err driven from flops.

Reset
REQ-036 rst low at an edge SHALL force IDLE, clear mask, counters, result registers, err; outputs nr_input_valid, res_valid, busy, done, err = 0; nr_input, res_data, res_index = 0.
REQ-037 Reset mid-pass SHALL abort immediately; buffer contents need not be cleared and remain usable.

Verification
REQ-038 numWeight=4, numNeuron=3: load 1,2,3,4; start at T -> nr_input_valid T+2..T+5 with data 1,2,3,4, busy from T+1.
REQ-039 Neurons return 0x10,0x20,0x30 on nr_outvalid one-hot over 3 cycles, res_ready=1 -> res (0,0x10),(1,0x20),(2,0x30) consecutive, then done pulse one cycle, busy low after.
REQ-040 res_ready low 5 cycles with res_index=1 -> res_data=0x20 held, index unchanged; resumes on ready.
REQ-041 Neuron 2 never valid, waitMax=16 -> DRAIN after 16 WAIT_NR cycles, err=1, index 2 data 0; err clears on next start.
REQ-042 start and in_wr_en asserted during STREAM -> no restart, buffer unchanged, sequence as REQ-038.
REQ-043 rst low during DRAIN index 1 -> next cycle IDLE, all outputs 0; new start replays buffer correctly.
